// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock, signed/unsigned with divide-by-zero flag
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, qb, dsr, orig;
  logic q_neg, r_neg, dz, a_neg, b_neg;
  logic [WIDTH:0] shifted, diff;
  // operand signs and the trial subtraction of the current step
  always_comb begin
    a_neg = signed_op & dividend[WIDTH-1];
    b_neg = signed_op & divisor[WIDTH-1];
    shifted = {rem, qb[WIDTH-1]};
    diff = shifted - {1'b0, dsr};
  end
  // control FSM and datapath registers; results only change at the fix step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      qb <= '0;
      dsr <= '0;
      orig <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          qb <= a_neg ? -dividend : dividend;
          dsr <= b_neg ? -divisor : divisor;
          orig <= dividend;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          dz <= divisor == '0;
          rem <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          qb <= {qb[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient <= dz ? '1 : (q_neg ? -qb : qb);
          remainder <= dz ? orig : (r_neg ? -rem : rem);
          div_zero <= dz;
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider against an arithmetic reference model
module tb_seq_divider;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, signed_op = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_zero;
  logic [W-1:0] quotient, remainder;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    int due;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [W-1:0] pq, pr;
  logic pz;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic s, int due);
    exp_t e;
    logic signed [W-1:0] sa, sd;
    e.due = due;
    e.dz = 1'b0;
    sa = a;
    sd = b;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dz = 1'b1;
    end else if (s && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      e.q = a;
      e.r = '0;
    end else if (s) begin
      e.q = sa / sd;
      e.r = sa % sd;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic s);
    @(negedge clk);
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    exp_q.push_back(model(a, b, s, cyc + 1 + W + 1));
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    signed_op = $urandom_range(0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  // monitor: pop and compare on every done, otherwise results must hold
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pq = quotient;
        pr = remainder;
        pz = div_zero;
      end else begin
        check("busy_and_done", {31'b0, busy & done}, 32'd0);
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
            check("latency", cyc, e.due);
          end
        end else begin
          check("hold", {quotient ^ pq} | {remainder ^ pr} | {31'b0, div_zero ^ pz}, '0);
        end
        pq = quotient;
        pr = remainder;
        pz = div_zero;
      end
    end
  end

  initial begin
    logic [W-1:0] da [10] = '{32'd28, 32'd4, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd0};
    logic [W-1:0] db [10] = '{32'd7, 32'd2, 32'd2, 32'hFFFFFFFE, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd9};
    logic ds [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int e0;
    repeat (3) @(negedge clk);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_flags", {29'b0, busy, done, div_zero}, '0);
    reset = 1'b0;
    issue(da[0], db[0], ds[0]);
    for (int k = 0; k <= W; k++) begin
      check("busy_calc", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    check("busy_after", {31'b0, busy}, 32'd0);
    check("done_edge", {31'b0, done}, 32'd1);
    for (int i = 1; i < 10; i++) begin
      issue(da[i], db[i], ds[i]);
      wait_done();
    end
    issue(32'd100, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    dividend = 32'd9;
    divisor = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    dividend = 32'd77;
    divisor = 32'd5;
    signed_op = 1'b0;
    start = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(model(32'd77, 32'd5, 1'b0, e0 + W + 1));
    exp_q.push_back(model(32'd77, 32'd5, 1'b0, e0 + W + 3 + W + 1));
    wait_done();
    @(negedge clk);
    wait_done();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      int m;
      a = $urandom;
      b = $urandom;
      m = $urandom_range(0, 5);
      if (m == 0) b = '0;
      if (m == 1) b = W'($urandom_range(1, 16));
      if (m == 2) b = -W'($urandom_range(1, 16));
      if (m == 3) a = W'($urandom_range(0, 1000));
      issue(a, b, 1'($urandom_range(0, 1)));
      wait_done();
    end
    issue(32'd100, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    check("arst_quotient", quotient, '0);
    check("arst_remainder", remainder, '0);
    check("arst_flags", {29'b0, busy, done, div_zero}, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd50, 32'd5, 1'b0);
    wait_done();
    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
